// File: rtl/mux_nx_pipe.sv
// Registered N-to-1 source selector with per-channel valid/ready handshakes.
// Picks one channel per cycle, either fixed by sel or round-robin over valid channels.
module mux_nx_pipe #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 mode,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_src,
   output logic                 out_valid,
   input  logic                 out_ready
);

   generate
      if (N < 2 || SEL_W != $clog2(N)) begin : g_bad_param
         $error("mux_nx_pipe: need N >= 2 and SEL_W == clog2(N)");
      end
   endgenerate

   logic [N-1:0][WIDTH-1:0] data;
   logic                    load_en;
   logic                    gnt_vld;
   logic [SEL_W-1:0]        gnt;
   logic [SEL_W-1:0]        rr_ptr;
   int                      j;

   assign data    = in_data;
   assign load_en = !out_valid || out_ready;

   // Round-robin scans downward so the candidate closest to rr_ptr wins last.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      j       = 0;
      if (!mode) begin
         for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
               gnt     = SEL_W'(i);
               gnt_vld = 1'b1;
            end
         end
      end else begin
         for (int k = N-1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            if (in_valid[j]) begin
               gnt     = SEL_W'(j);
               gnt_vld = 1'b1;
            end
         end
      end
      if (!load_en || rst) gnt_vld = 1'b0;
   end

   always_comb begin
      in_ready = '0;
      if (gnt_vld) in_ready[gnt] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         rr_ptr    <= '0;
      end else if (load_en) begin
         if (gnt_vld) begin
            out_data  <= data[gnt];
            out_src   <= gnt;
            out_valid <= 1'b1;
            // pointer only advances on round-robin grants
            if (mode) rr_ptr <= (gnt == SEL_W'(N-1)) ? '0 : gnt + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_nx_pipe.sv
// Self-checking bench for mux_nx_pipe: directed scenarios plus random traffic
// compared against a cycle-level reference model.
module tb_mux_nx_pipe;
   localparam int W = 32;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic [1:0]     sel = '0;
   logic           mode = 1'b0;
   logic [W-1:0]   out_data;
   logic [1:0]     out_src;
   logic           out_valid;
   logic           out_ready = 1'b1;

   logic [3*W-1:0] in_data3 = '0;
   logic [2:0]     in_valid3 = '0;
   logic [2:0]     in_ready3;
   logic [1:0]     sel3 = '0;
   logic           mode3 = 1'b0;
   logic [W-1:0]   out_data3;
   logic [1:0]     out_src3;
   logic           out_valid3;
   logic           out_ready3 = 1'b1;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_src;
   int           m_ptr;

   always #5 clk = ~clk;

   mux_nx_pipe #(.WIDTH(W), .N(N), .SEL_W(2)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode), .out_data(out_data), .out_src(out_src),
      .out_valid(out_valid), .out_ready(out_ready));

   mux_nx_pipe #(.WIDTH(W), .N(3), .SEL_W(2)) u_dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .sel(sel3), .mode(mode3), .out_data(out_data3), .out_src(out_src3),
      .out_valid(out_valid3), .out_ready(out_ready3));

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected grant index, -1 when nothing is granted this cycle.
   function automatic int m_grant();
      if (m_valid && !out_ready) return -1;
      if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
      for (int k = 0; k < N; k++)
         if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic m_reset();
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
   endtask

   // One clock: check handshake and outputs before the edge, then advance the model.
   task automatic cyc();
      int g;
      #1;
      g = m_grant();
      chk("in_ready", W'(in_ready), (g >= 0) ? W'(1 << g) : '0);
      chk("out_valid", W'(out_valid), W'(m_valid));
      if (m_valid) begin
         chk("out_data", out_data, m_data);
         chk("out_src", W'(out_src), W'(m_src));
      end
      @(posedge clk);
      if (!m_valid || out_ready) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_src   = g;
            if (mode) m_ptr = (g + 1) % N;
         end else begin
            m_valid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", W'(out_valid), '0);
      chk("rst_data", out_data, '0);
      chk("rst_src", W'(out_src), '0);
      chk("rst_ready", W'(in_ready), '0);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      m_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // fixed select, data word i = i
      for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i);
      in_valid = '1; out_ready = 1'b1; mode = 1'b0;
      for (int i = 0; i < N; i++) begin
         sel = 2'(i);
         cyc();
         chk("fix_data", out_data, W'(i));
         chk("fix_src", W'(out_src), W'(i));
      end

      // backpressure holds word 2 with no grants
      sel = 2'd2;
      cyc();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp_data", out_data, W'(2));
         chk("bp_ready", W'(in_ready), '0);
      end
      out_ready = 1'b1; in_valid = '0;
      cyc();
      chk("bp_drain", W'(out_valid), '0);

      // reset mid-transfer with a word held
      in_valid = '1; sel = 2'd1;
      cyc();
      chk("pre_rst_valid", W'(out_valid), 1);
      do_reset();

      // round-robin, all valid: 0,1,2,3,0,1
      mode = 1'b1; in_valid = '1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("rr_src", W'(out_src), W'(i % N));
      end
      do_reset();
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("rr_sparse", W'(out_src), (i % 2 == 0) ? W'(1) : W'(3));
      end

      // mode switch: 0,1 then sel=3 twice, then round-robin resumes at 2
      do_reset();
      in_valid = '1;
      mode = 1'b1; cyc(); chk("ms_src0", W'(out_src), 0);
      cyc();               chk("ms_src1", W'(out_src), 1);
      mode = 1'b0; sel = 2'd3;
      cyc();               chk("ms_src2", W'(out_src), 3);
      cyc();               chk("ms_src3", W'(out_src), 3);
      mode = 1'b1;
      cyc();               chk("ms_src4", W'(out_src), 2);

      // single valid channel in round-robin
      in_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rr_single", W'(out_src), 2);
      end

      // invalid select on the 3-channel instance
      for (int i = 0; i < 3; i++) in_data3[i*W +: W] = W'(16 + i);
      in_valid3 = '1; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
      @(negedge clk);
      chk("n3_valid", W'(out_valid3), 1);
      chk("n3_data", out_data3, W'(16));
      sel3 = 2'd3;
      #1;
      chk("n3_ready", W'(in_ready3), '0);
      @(negedge clk);
      chk("n3_drain", W'(out_valid3), '0);
      chk("n3_ready2", W'(in_ready3), '0);
      @(negedge clk);
      chk("n3_idle", W'(out_valid3), '0);

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom();
         in_valid  = 4'($urandom());
         sel       = 2'($urandom());
         mode      = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      out_ready = 1'b1;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
